// File: rtl/calendar_date_cascade_if.sv
// Bus bundle for the calendar date stage: tick/set controls in, date fields out.
// Q_week exists only when CALENDAR_WEEKDAY_EN is defined.
interface calendar_date_cascade_if;
   logic        En;
   logic        day_tick;
   logic        set_en;
   logic [1:0]  set_sel;
   logic [15:0] set_val;
   logic        set_strobe;
   logic [4:0]  Q_day;
   logic [3:0]  Q_month;
   logic [15:0] Q_year;
   logic [4:0]  days_in_month;
   logic        leap;
   logic        C_year;
   logic        set_err;
`ifdef CALENDAR_WEEKDAY_EN
   logic [2:0]  Q_week;
`endif

   modport master (
      output En, day_tick, set_en, set_sel, set_val, set_strobe,
      input  Q_day, Q_month, Q_year, days_in_month, leap, C_year, set_err
`ifdef CALENDAR_WEEKDAY_EN
      , input Q_week
`endif
   );

   modport slave (
      input  En, day_tick, set_en, set_sel, set_val, set_strobe,
      output Q_day, Q_month, Q_year, days_in_month, leap, C_year, set_err
`ifdef CALENDAR_WEEKDAY_EN
      , output Q_week
`endif
   );
endinterface

// File: rtl/calendar_date_cascade.sv
// Day/month/year stage fed by the hour counter carry; Gregorian leap rules,
// validated field setting. Optional weekday counter via CALENDAR_WEEKDAY_EN.
module calendar_date_cascade #(
   parameter logic [15:0] YEAR_INIT  = 16'd2023,
   parameter logic [3:0]  MONTH_INIT = 4'd1,
   parameter logic [4:0]  DAY_INIT   = 5'd1,
   parameter logic [15:0] YEAR_MIN   = 16'd2000,
   parameter logic [15:0] YEAR_MAX   = 16'd2099,
   parameter logic [2:0]  WEEK_INIT  = 3'd0
) (
   input logic                   CP,
   input logic                   nCR,
   calendar_date_cascade_if.slave bus
);

   function automatic logic is_leap(input logic [15:0] y);
      return (y[1:0] == 2'd0) &&
             (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
   endfunction

   function automatic logic [4:0] month_days(input logic [3:0] m, input logic [15:0] y);
      case (m)
         4'd2:                   return is_leap(y) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         default:                return 5'd31;
      endcase
   endfunction

   logic [4:0]  day_q, day_d;
   logic [3:0]  month_q, month_d;
   logic [15:0] year_q, year_d;
   logic        c_year_q, c_year_d;
   logic        set_err_q, set_err_d;
   logic        tick_prev_q, tick_prev_d;
   logic        tick_rise;
   logic [4:0]  dim_cur;
   logic [4:0]  dim_new;
`ifdef CALENDAR_WEEKDAY_EN
   logic [2:0]  week_q, week_d;
`else
   logic        unused_week_init;
   assign unused_week_init = ^WEEK_INIT;
`endif

   assign tick_rise = bus.day_tick & ~tick_prev_q;
   assign dim_cur   = month_days(month_q, year_q);

   always_comb begin
      day_d       = day_q;
      month_d     = month_q;
      year_d      = year_q;
      c_year_d    = 1'b0;
      set_err_d   = 1'b0;
      tick_prev_d = bus.day_tick;
      dim_new     = dim_cur;
`ifdef CALENDAR_WEEKDAY_EN
      week_d      = week_q;
`endif
      if (bus.set_en) begin
         if (bus.set_strobe) begin
            case (bus.set_sel)
               2'd0: begin
                  if (bus.set_val >= 16'd1 && bus.set_val <= {11'd0, dim_cur})
                     day_d = bus.set_val[4:0];
                  else
                     set_err_d = 1'b1;
               end
               2'd1: begin
                  if (bus.set_val >= 16'd1 && bus.set_val <= 16'd12) begin
                     month_d = bus.set_val[3:0];
                     dim_new = month_days(bus.set_val[3:0], year_q);
                     // Keep the day legal for the new month (e.g. 31 -> 30).
                     if (day_q > dim_new) day_d = dim_new;
                  end else begin
                     set_err_d = 1'b1;
                  end
               end
               2'd2: begin
                  if (bus.set_val >= YEAR_MIN && bus.set_val <= YEAR_MAX) begin
                     year_d  = bus.set_val;
                     dim_new = month_days(month_q, bus.set_val);
                     if (day_q > dim_new) day_d = dim_new;
                  end else begin
                     set_err_d = 1'b1;
                  end
               end
               default: begin
`ifdef CALENDAR_WEEKDAY_EN
                  if (bus.set_val <= 16'd6) week_d = bus.set_val[2:0];
                  else                      set_err_d = 1'b1;
`else
                  set_err_d = 1'b1;
`endif
               end
            endcase
         end
      end else if (bus.En && tick_rise) begin
`ifdef CALENDAR_WEEKDAY_EN
         week_d = (week_q == 3'd6) ? 3'd0 : week_q + 3'd1;
`endif
         if (day_q < dim_cur) begin
            day_d = day_q + 5'd1;
         end else if (month_q < 4'd12) begin
            day_d   = 5'd1;
            month_d = month_q + 4'd1;
         end else begin
            day_d    = 5'd1;
            month_d  = 4'd1;
            c_year_d = 1'b1;
            year_d   = (year_q == YEAR_MAX) ? YEAR_MIN : year_q + 16'd1;
         end
      end
   end

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         day_q       <= DAY_INIT;
         month_q     <= MONTH_INIT;
         year_q      <= YEAR_INIT;
         c_year_q    <= 1'b0;
         set_err_q   <= 1'b0;
         tick_prev_q <= 1'b0;
`ifdef CALENDAR_WEEKDAY_EN
         week_q      <= WEEK_INIT;
`endif
      end else begin
         day_q       <= day_d;
         month_q     <= month_d;
         year_q      <= year_d;
         c_year_q    <= c_year_d;
         set_err_q   <= set_err_d;
         tick_prev_q <= tick_prev_d;
`ifdef CALENDAR_WEEKDAY_EN
         week_q      <= week_d;
`endif
      end
   end

   assign bus.Q_day         = day_q;
   assign bus.Q_month       = month_q;
   assign bus.Q_year        = year_q;
   assign bus.days_in_month = dim_cur;
   assign bus.leap          = is_leap(year_q);
   assign bus.C_year        = c_year_q;
   assign bus.set_err       = set_err_q;
`ifdef CALENDAR_WEEKDAY_EN
   assign bus.Q_week        = week_q;
`endif

endmodule

// File: tb/tb_calendar_date_cascade.sv
// Randomized bench for calendar_date_cascade against a plain calendar model;
// also walks the leap-day, year-wrap, clamp and dropped-tick cases.
module tb_calendar_date_cascade;

   logic CP  = 1'b0;
   logic nCR = 1'b0;
   always #5 CP = ~CP;

   calendar_date_cascade_if cal_if ();

   calendar_date_cascade dut (
      .CP  (CP),
      .nCR (nCR),
      .bus (cal_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_day, m_month, m_year, m_week;
   bit m_prev;
   bit exp_cy, exp_err;

   function automatic bit ref_leap(int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int ref_dim(int m, int y);
      int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      if (m < 1 || m > 12) return 31;
      return tbl[m-1] + ((m == 2 && ref_leap(y)) ? 1 : 0);
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_day = 1; m_month = 1; m_year = 2023; m_week = 0;
      m_prev = 1'b0; exp_cy = 1'b0; exp_err = 1'b0;
   endtask

   task automatic model_step(bit en, bit tick, bit sen, int sel, int val, bit stb);
      bit rise;
      rise    = tick && !m_prev;
      m_prev  = tick;
      exp_cy  = 1'b0;
      exp_err = 1'b0;
      if (sen) begin
         if (stb) begin
            case (sel)
               0: if (val >= 1 && val <= ref_dim(m_month, m_year)) m_day = val;
                  else exp_err = 1'b1;
               1: if (val >= 1 && val <= 12) begin
                     m_month = val;
                     if (m_day > ref_dim(m_month, m_year)) m_day = ref_dim(m_month, m_year);
                  end else exp_err = 1'b1;
               2: if (val >= 2000 && val <= 2099) begin
                     m_year = val;
                     if (m_day > ref_dim(m_month, m_year)) m_day = ref_dim(m_month, m_year);
                  end else exp_err = 1'b1;
               default: begin
`ifdef CALENDAR_WEEKDAY_EN
                  if (val <= 6) m_week = val;
                  else exp_err = 1'b1;
`else
                  exp_err = 1'b1;
`endif
               end
            endcase
         end
      end else if (en && rise) begin
         m_week = (m_week + 1) % 7;
         m_day  = m_day + 1;
         if (m_day > ref_dim(m_month, m_year)) begin
            m_day   = 1;
            m_month = m_month + 1;
            if (m_month > 12) begin
               m_month = 1;
               exp_cy  = 1'b1;
               m_year  = (m_year == 2099) ? 2000 : m_year + 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("Q_day",         32'(cal_if.Q_day),         32'(m_day));
      check("Q_month",       32'(cal_if.Q_month),       32'(m_month));
      check("Q_year",        32'(cal_if.Q_year),        32'(m_year));
      check("days_in_month", 32'(cal_if.days_in_month), 32'(ref_dim(m_month, m_year)));
      check("leap",          32'(cal_if.leap),          32'(ref_leap(m_year)));
      check("C_year",        32'(cal_if.C_year),        32'(exp_cy));
      check("set_err",       32'(cal_if.set_err),       32'(exp_err));
`ifdef CALENDAR_WEEKDAY_EN
      check("Q_week",        32'(cal_if.Q_week),        32'(m_week));
`endif
   endtask

   task automatic step(bit en, bit tick, bit sen, int sel, int val, bit stb);
      @(negedge CP);
      cal_if.En         = en;
      cal_if.day_tick   = tick;
      cal_if.set_en     = sen;
      cal_if.set_sel    = 2'(sel);
      cal_if.set_val    = 16'(val);
      cal_if.set_strobe = stb;
      model_step(en, tick, sen, sel, val, stb);
      @(posedge CP);
      #1;
      compare_all();
   endtask

   task automatic set_field(int sel, int val);
      step(1'b1, 1'b0, 1'b1, sel, val, 1'b1);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic tick_pulse();
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   initial begin
      int r, sel, val;
      cal_if.En = 1'b0; cal_if.day_tick = 1'b0; cal_if.set_en = 1'b0;
      cal_if.set_sel = 2'd0; cal_if.set_val = 16'd0; cal_if.set_strobe = 1'b0;
      model_reset();
      #12;
      compare_all();
      check("rst_date", 32'({cal_if.Q_year, 7'd0, cal_if.Q_month, cal_if.Q_day}),
            32'({16'd2023, 7'd0, 4'd1, 5'd1}));
      @(negedge CP);
      nCR = 1'b1;
      idle();

      // Leap day walk in 2024
      set_field(2, 2024); set_field(1, 2); set_field(0, 28);
      tick_pulse();
      check("feb29", 32'(cal_if.Q_day), 32'd29);
      tick_pulse();
      check("mar01", 32'(cal_if.Q_month), 32'd3);

      // Non-leap February, century rules
      set_field(2, 2023); set_field(1, 2); set_field(0, 28);
      tick_pulse();
      set_field(2, 2000);
      check("leap2000", 32'(cal_if.leap), 32'd1);
      set_field(2, 2100);
      check("err2100", 32'(cal_if.set_err), 32'd1);

      // Year wrap with carry pulse
      set_field(2, 2099); set_field(1, 12); set_field(0, 31);
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      check("c_year_hi", 32'(cal_if.C_year), 32'd1);
      idle();
      check("c_year_lo", 32'(cal_if.C_year), 32'd0);

      // Clamp and rejected sets
      set_field(0, 31); set_field(1, 4);
      check("clamp30", 32'(cal_if.Q_day), 32'd30);
      set_field(0, 31);
      set_field(3, 2);
      set_field(1, 2); set_field(2, 2024); set_field(0, 29); set_field(2, 2023);
      check("clamp28", 32'(cal_if.Q_day), 32'd28);

      // Held tick, disabled tick, tick during set mode, stray strobe
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      idle();
      tick_pulse();
      step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
      idle();
      step(1'b1, 1'b0, 1'b0, 0, 5, 1'b1);
      step(1'b0, 1'b0, 1'b1, 0, 1, 1'b1);

      // Asynchronous reset in mid-operation
      set_field(1, 7);
      @(negedge CP);
      cal_if.set_en = 1'b1; cal_if.set_strobe = 1'b1; cal_if.set_val = 16'd9;
      #2 nCR = 1'b0;
      #1 model_reset();
      compare_all();
      cal_if.set_en = 1'b0; cal_if.set_strobe = 1'b0;
      @(negedge CP);
      nCR = 1'b1;

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 19);
         if (r < 3) begin
            sel = $urandom_range(0, 3);
            case (sel)
               0: val = $urandom_range(0, 32);
               1: val = $urandom_range(0, 14);
               2: val = ($urandom_range(0, 3) == 0) ? $urandom_range(2097, 2099)
                                                    : $urandom_range(1995, 2105);
               default: val = $urandom_range(0, 8);
            endcase
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1, sel, val, 1'b1);
         end else if (r == 3) begin
            step(1'b1, $urandom_range(0, 1) == 1, 1'b1, 0, 0, 1'b0);
         end else if (r == 4) begin
            step(1'b1, $urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 3), 40, 1'b1);
         end else begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, 1'b0, 0, 0, 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/calendar_date_cascade.md
Name: calendar_date_cascade

Overview:
- Day/month/year stage that sits directly downstream of the hour-level CounterN chain.
- Consumes the hour counter's carry as a day tick and maintains the calendar date with Gregorian leap-year rules.
- Exports days-in-month, the leap flag and a year carry to the display and alarm logic.
- Supports synchronous field-by-field setting with validation.

Parameters:
- YEAR_INIT, 2023, year loaded on reset
- MONTH_INIT, 1, month loaded on reset (1..12)
- DAY_INIT, 1, day loaded on reset (must be valid for MONTH_INIT/YEAR_INIT)
- YEAR_MIN, 2000, lowest legal year; wrap target
- YEAR_MAX, 2099, highest legal year
- WEEK_INIT, 0, weekday loaded on reset (0..6; used only with WEEKDAY_EN)

Ports:
- CP  in  1  clock, rising edge
- nCR  in  1  asynchronous active-low reset
- En  in  1  1 = day ticks advance the date; 0 = ticks dropped
- day_tick  in  1  carry from the hour counter; level, sampled on CP
- set_en  in  1  1 = set mode; ticks suppressed
- set_sel  in  2  field select: 0 day, 1 month, 2 year, 3 weekday
- set_val  in  16  value to load
- set_strobe  in  1  one-cycle load request; honoured only while set_en=1
- Q_day  out  5  day of month, 1..31
- Q_month  out  4  month, 1..12
- Q_year  out  16  year, YEAR_MIN..YEAR_MAX
- days_in_month  out  5  28/29/30/31 for the current Q_month/Q_year, combinational
- leap  out  1  1 when Q_year is a leap year, combinational
- C_year  out  1  one-cycle pulse on the Dec 31 -> Jan 1 transition
- set_err  out  1  one-cycle pulse on a rejected set

Behaviour:
- Reset (nCR=0, async):
  - Q_day=DAY_INIT, Q_month=MONTH_INIT, Q_year=YEAR_INIT.
  - C_year=0, set_err=0; the internal tick_prev register = 0.
- Tick detection:
  - tick_rise = day_tick & ~tick_prev; tick_prev <= day_tick every cycle, including while set_en=1 or En=0.
  - A day_tick held high for N cycles produces one advance.
- Advance happens on tick_rise when En=1 and set_en=0. The date updates on the same CP edge that samples tick_rise.
  - If Q_day < days_in_month: Q_day+1.
  - Else if Q_month < 12: Q_day=1, Q_month+1.
  - Else: Q_day=1, Q_month=1, and C_year=1 for exactly one cycle. Q_year = YEAR_MIN if Q_year==YEAR_MAX, otherwise Q_year+1.
- Leap rule: leap = (Y%4==0) && ((Y%100!=0) || (Y%400==0)).
- days_in_month table:
  - Feb = 28 + leap.
  - Apr/Jun/Sep/Nov = 30.
  - All other months = 31.
- Dropped ticks: a tick_rise with En=0 or set_en=1 is dropped, not queued.
- Set path (set_en=1 and set_strobe=1, applied next edge):
  - sel 0: accept 1 <= set_val <= days_in_month.
  - sel 1: accept 1..12.
  - sel 2: accept YEAR_MIN..YEAR_MAX.
  - sel 3: see Optional Feature.
  - A rejected set pulses set_err for one cycle and leaves all state unchanged.
  - A set_strobe with set_en=0 is ignored and does not raise set_err.
- Clamp: after an accepted month or year set, if Q_day exceeds the new days_in_month, Q_day becomes the new days_in_month on the same edge (e.g. day 31, set month 4 -> day 30; Feb 29 2024, set year 2023 -> Feb 28).
- Set with En=0: accepted sets are applied regardless of En.
- Reset mid-operation forces the reset values immediately; any pending strobe or tick is lost.
- Register rules:
  - C_year and set_err are registered and default to 0 each cycle.
  - All Q outputs are registered.

Optional Feature:
- Macro: CALENDAR_WEEKDAY_EN.
- Defined:
  - Adds output Q_week (3 bits, 0..6), reset to WEEK_INIT.
  - Q_week increments on every applied advance, wrapping 6 -> 0.
  - set_sel=3 loads Q_week when set_val <= 6; otherwise set_err.
  - Date sets do not change Q_week.
- Undefined:
  - No Q_week port.
  - set_sel=3 always raises set_err.

Test Plan:
- Reset with defaults -> Q = 2023-01-01, days_in_month=31, leap=0, C_year=0, set_err=0.
- Set year 2024, month 2, day 28; set_en=0; two tick pulses -> 2024-02-29, then 2024-03-01; leap=1 throughout.
- Set 2023-02-28; one tick -> 2023-03-01; set year 2000 -> leap=1; set year 2100 -> set_err pulse, year unchanged.
- Set 2099-12-31; one tick -> 2000-01-01 with C_year high for exactly one cycle.
- Day 31, month 1; set month 4 -> Q_day=30; set day 31 -> set_err, Q_day stays 30; set_sel=3 without macro -> set_err.
- day_tick held high 5 cycles -> single advance.
- Tick with En=0 -> no change.
- Tick while set_en=1 -> no change, and no advance after set_en falls.
- With macro, WEEK_INIT=6, one tick -> Q_week=0.
